// File: rtl/lock_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lock_key_ctrl
// Purpose  : Key-management controller for a 3-bit-key logic-locked netlist.
//            Accepts a candidate key over a valid/ready handshake, drives it
//            onto the netlist key pins, and sweeps all 16 {A,B,C,D} vectors,
//            comparing the netlist output against a golden truth table.
//            A passing key unlocks functional pass-through. A failing key
//            bumps a consecutive-failure counter. Reaching MAX_FAIL failures
//            locks the block out until reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   key_in     in   3  candidate key {K3,K2,K1}
//   key_valid  in   1  candidate present
//   key_ready  out  1  controller can accept a key (IDLE or UNLOCKED)
//   func_in    in   4  functional vector {A,B,C,D}
//   func_out   out  1  netlist Y when unlocked, else 0
//   lk_abcd    out  4  registered drive to netlist A,B,C,D
//   lk_key     out  3  registered drive to netlist {K3,K2,K1}
//   lk_y       in   1  netlist output Y
//   busy       out  1  check in progress
//   unlocked   out  1  key verified
//   locked_out out  1  lockout active
//   fail_cnt   out  3  consecutive failure count
// ============================================================================
module lock_key_ctrl #(
  parameter logic [15:0] GOLDEN_TT = 16'h8AFA,
  parameter int unsigned MAX_FAIL  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] func_in,
  output logic       func_out,
  output logic [3:0] lk_abcd,
  output logic [2:0] lk_key,
  input  logic       lk_y,
  output logic       busy,
  output logic       unlocked,
  output logic       locked_out,
  output logic [2:0] fail_cnt
);

  localparam logic [1:0] c_ST_IDLE     = 2'd0;
  localparam logic [1:0] c_ST_CHECK    = 2'd1;
  localparam logic [1:0] c_ST_UNLOCKED = 2'd2;
  localparam logic [1:0] c_ST_LOCKOUT  = 2'd3;

  localparam logic [2:0] c_MAX_FAIL = 3'(MAX_FAIL);

  logic [1:0] r_state;
  logic [3:0] r_vec_cnt;
  logic       r_mismatch;

  logic       w_transfer;
  logic       w_cmp_bad;
  logic       w_fail_final;
  logic       w_last_vec;
  logic [2:0] w_fail_inc;

  assign key_ready  = (r_state == c_ST_IDLE) || (r_state == c_ST_UNLOCKED);
  assign busy       = (r_state == c_ST_CHECK);
  assign unlocked   = (r_state == c_ST_UNLOCKED);
  assign locked_out = (r_state == c_ST_LOCKOUT);
  assign func_out   = (r_state == c_ST_UNLOCKED) ? lk_y : 1'b0;

  assign w_transfer = key_valid && key_ready;

  // lk_abcd tracks r_vec_cnt during the sweep, so lk_y corresponds to the
  // current vector index and can be compared against the golden bit directly.
  assign w_cmp_bad    = lk_y ^ GOLDEN_TT[r_vec_cnt];
  // Final verdict must fold in the compare of the last vector itself.
  assign w_fail_final = r_mismatch | w_cmp_bad;
  assign w_last_vec   = (r_vec_cnt == 4'hF);
  assign w_fail_inc   = fail_cnt + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_vec_cnt  <= 4'd0;
      r_mismatch <= 1'b0;
      lk_key     <= 3'd0;
      lk_abcd    <= 4'd0;
      fail_cnt   <= 3'd0;
    end else begin
      case (r_state)
        c_ST_IDLE, c_ST_UNLOCKED: begin
          if (w_transfer) begin
            // A re-key from UNLOCKED restarts exactly like a fresh key;
            // fail_cnt is left untouched.
            lk_key     <= key_in;
            r_vec_cnt  <= 4'd0;
            lk_abcd    <= 4'd0;
            r_mismatch <= 1'b0;
            r_state    <= c_ST_CHECK;
          end else if (r_state == c_ST_UNLOCKED) begin
            lk_abcd <= func_in;
          end
        end

        c_ST_CHECK: begin
          // Fixed 16-cycle sweep, no early exit: timing reveals nothing
          // about where a wrong key first diverges.
          r_vec_cnt  <= r_vec_cnt + 4'd1;
          lk_abcd    <= r_vec_cnt + 4'd1;
          r_mismatch <= w_fail_final;
          if (w_last_vec) begin
            lk_abcd <= 4'd0;
            if (!w_fail_final) begin
              r_state  <= c_ST_UNLOCKED;
              fail_cnt <= 3'd0;
            end else begin
              lk_key <= 3'd0;
              if (w_fail_inc == c_MAX_FAIL) begin
                r_state  <= c_ST_LOCKOUT;
                fail_cnt <= c_MAX_FAIL;
              end else begin
                r_state  <= c_ST_IDLE;
                fail_cnt <= w_fail_inc;
              end
            end
          end
        end

        c_ST_LOCKOUT: begin
          lk_key  <= 3'd0;
          lk_abcd <= 4'd0;
        end

        default: begin
          r_state <= c_ST_IDLE;
          lk_key  <= 3'd0;
          lk_abcd <= 4'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lock_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_key_ctrl
// Purpose  : Directed self-checking bench for lock_key_ctrl. Includes a
//            behavioural model of the locked netlist: with the correct key
//            3'b110 it reproduces the golden table; any other key flips Y
//            at a single key-dependent index (index 12 for key 3'b000).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_key_ctrl;

  localparam logic [15:0] c_GOLDEN   = 16'h8AFA;
  localparam logic [2:0]  c_GOOD_KEY = 3'b110;

  logic       clk;
  logic       rst_n;
  logic [2:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] func_in;
  logic       func_out;
  logic [3:0] lk_abcd;
  logic [2:0] lk_key;
  logic       lk_y;
  logic       busy;
  logic       unlocked;
  logic       locked_out;
  logic [2:0] fail_cnt;

  int n_checks = 0;
  int n_errors = 0;

  lock_key_ctrl #(
    .GOLDEN_TT (16'h8AFA),
    .MAX_FAIL  (3)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .func_in    (func_in),
    .func_out   (func_out),
    .lk_abcd    (lk_abcd),
    .lk_key     (lk_key),
    .lk_y       (lk_y),
    .busy       (busy),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt)
  );

  // Locked netlist model.
  logic [3:0] w_bad_idx;
  always_comb begin
    w_bad_idx = 4'd12 ^ {1'b0, lk_key};
    lk_y      = c_GOLDEN[lk_abcd] ^ ((lk_key != c_GOOD_KEY) && (lk_abcd == w_bad_idx));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_ready"},  key_ready,  1);
    check({tag, "_busy"},   busy,       0);
    check({tag, "_unlk"},   unlocked,   0);
    check({tag, "_lock"},   locked_out, 0);
    check({tag, "_fcnt"},   fail_cnt,   0);
    check({tag, "_key"},    lk_key,     0);
    check({tag, "_abcd"},   lk_abcd,    0);
    check({tag, "_fout"},   func_out,   0);
  endtask

  // Transfer one key and follow the 16-cycle sweep. Returns at the negedge
  // after the 16th CHECK edge. With hold=1, key_valid stays high through the
  // sweep while key_in is changed to alt_key, which must not be taken.
  task automatic run_key(input logic [2:0] key, input bit hold, input logic [2:0] alt_key);
    @(negedge clk);
    key_in    = key;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) key_valid = 1'b0;
    else       key_in    = alt_key;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("sweep_abcd_%0d", i), lk_abcd, i);
      check($sformatf("sweep_busy_%0d", i), busy, 1);
      check($sformatf("sweep_rdy_%0d", i),  key_ready, 0);
      check($sformatf("sweep_key_%0d", i),  lk_key, key);
      check($sformatf("sweep_unlk_%0d", i), unlocked, 0);
      @(posedge clk);
    end
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic set_func(input logic [3:0] v, input logic exp_y, input string tag);
    @(negedge clk);
    func_in = v;
    @(negedge clk);
    check({tag, "_abcd"}, lk_abcd, v);
    check({tag, "_fout"}, func_out, exp_y);
  endtask

  initial begin
    rst_n     = 1'b1;
    key_in    = 3'd0;
    key_valid = 1'b0;
    func_in   = 4'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_reset("rst");
    rst_n = 1'b1;

    // Correct key: full sweep then unlock.
    run_key(c_GOOD_KEY, 1'b0, 3'd0);
    check("good_unlk",  unlocked, 1);
    check("good_busy",  busy, 0);
    check("good_fcnt",  fail_cnt, 0);
    check("good_rdy",   key_ready, 1);
    check("good_key",   lk_key, c_GOOD_KEY);
    set_func(4'b1111, 1'b1, "f15");
    set_func(4'b1100, 1'b0, "f12");
    set_func(4'b0001, 1'b1, "f01");
    set_func(4'b1000, 1'b0, "f08");

    // Re-key with a wrong key from UNLOCKED.
    run_key(3'b000, 1'b0, 3'd0);
    check("bad1_unlk", unlocked, 0);
    check("bad1_busy", busy, 0);
    check("bad1_fcnt", fail_cnt, 1);
    check("bad1_key",  lk_key, 0);
    check("bad1_rdy",  key_ready, 1);
    check("bad1_lock", locked_out, 0);
    func_in = 4'b1111;
    @(negedge clk);
    check("bad1_fout", func_out, 0);

    run_key(3'b001, 1'b0, 3'd0);
    check("bad2_fcnt", fail_cnt, 2);
    check("bad2_lock", locked_out, 0);
    run_key(3'b010, 1'b0, 3'd0);
    check("lk_lock", locked_out, 1);
    check("lk_fcnt", fail_cnt, 3);
    check("lk_rdy",  key_ready, 0);
    check("lk_key",  lk_key, 0);
    check("lk_abcd", lk_abcd, 0);

    // Key offered during lockout must be ignored.
    key_in    = c_GOOD_KEY;
    key_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("lk_ign_busy", busy, 0);
    check("lk_ign_lock", locked_out, 1);
    check("lk_ign_key",  lk_key, 0);
    check("lk_ign_fout", func_out, 0);
    check("lk_ign_unlk", unlocked, 0);
    key_valid = 1'b0;

    // Asynchronous reset mid-cycle, no clock edge in between.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle_reset("arst");
    @(negedge clk);
    rst_n = 1'b1;

    // Two failures then the correct key, valid held through the check.
    run_key(3'b011, 1'b0, 3'd0);
    run_key(3'b100, 1'b0, 3'd0);
    check("pre_fcnt", fail_cnt, 2);
    run_key(c_GOOD_KEY, 1'b1, 3'b000);
    check("rec_unlk", unlocked, 1);
    check("rec_fcnt", fail_cnt, 0);
    check("rec_key",  lk_key, c_GOOD_KEY);
    @(negedge clk);
    check("rec_unlk2", unlocked, 1);
    check("rec_busy2", busy, 0);

    // Reset during the 8th CHECK cycle.
    @(negedge clk);
    key_in    = c_GOOD_KEY;
    key_valid = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_abcd", lk_abcd, 7);
    rst_n = 1'b0;
    #1;
    check_idle_reset("mrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_key(c_GOOD_KEY, 1'b0, 3'd0);
    check("post_unlk", unlocked, 1);
    check("post_fcnt", fail_cnt, 0);
    set_func(4'b1011, 1'b1, "f11");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
